// File: rtl/kf8237_common_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kf8237_common_pkg
// Description : Shared state, transfer-mode and transfer-type encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package kf8237_common_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_SI = 3'd0;
    localparam state_t ST_S0 = 3'd1;
    localparam state_t ST_S1 = 3'd2;
    localparam state_t ST_S2 = 3'd3;
    localparam state_t ST_S3 = 3'd4;
    localparam state_t ST_S4 = 3'd5;
    localparam state_t ST_SC = 3'd6;

    localparam logic [1:0] MODE_DEMAND  = 2'b00;
    localparam logic [1:0] MODE_SINGLE  = 2'b01;
    localparam logic [1:0] MODE_BLOCK   = 2'b10;
    localparam logic [1:0] MODE_CASCADE = 2'b11;

    localparam logic [1:0] TYPE_VERIFY = 2'b00;
    localparam logic [1:0] TYPE_WRITE  = 2'b01;
    localparam logic [1:0] TYPE_READ   = 2'b10;

    // Lowest set bit wins so a malformed grant still yields a defined channel.
    function automatic logic [1:0] onehot_to_index(input logic [3:0] onehot);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (onehot[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kf8237_strobe_decoder.sv
`default_nettype none
// ============================================================================
// Module      : kf8237_strobe_decoder
// Description : Next-value decode of the four bus strobes from state and type.
// Revision    : 1.0 - initial release
// ============================================================================
module kf8237_strobe_decoder
    import kf8237_common_pkg::*;
#(
    parameter int EXTENDED_WRITE = 0
) (
    input  logic [2:0] state,
    input  logic [1:0] transfer_type,
    output logic       ior_n,
    output logic       iow_n,
    output logic       memr_n,
    output logic       memw_n
);

    logic read_on;
    logic write_on;

    always_comb begin
        read_on  = (state == ST_S2) || (state == ST_S3);
        write_on = (state == ST_S3) || ((EXTENDED_WRITE != 0) && (state == ST_S2));
        ior_n    = 1'b1;
        iow_n    = 1'b1;
        memr_n   = 1'b1;
        memw_n   = 1'b1;
        case (transfer_type)
            TYPE_WRITE: begin
                ior_n  = ~read_on;
                memw_n = ~write_on;
            end
            TYPE_READ: begin
                memr_n = ~read_on;
                iow_n  = ~write_on;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/kf8237_timing_and_control.sv
`default_nettype none
// ============================================================================
// Module      : kf8237_timing_and_control
// Description : 8237 bus-cycle FSM (HRQ/HLDA, strobes, READY, TC/EOP).
//               Optional KF8237_COMPRESSED_TIMING_EN adds compressed_timing.
// Revision    : 1.0 - initial release
// ============================================================================
module kf8237_timing_and_control
    import kf8237_common_pkg::*;
#(
    parameter int EXTENDED_WRITE = 0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       master_clear,
    input  logic       controller_disable,
    input  logic [3:0] encoded_dma,
    input  logic [7:0] mode_transfer,
    input  logic [7:0] mode_type,
    input  logic       hlda,
    input  logic       ready,
    input  logic       terminal_count,
    input  logic       eop_n_in,
`ifdef KF8237_COMPRESSED_TIMING_EN
    input  logic       compressed_timing,
`endif
    output logic       hrq,
    output logic       aen,
    output logic       adstb,
    output logic       ior_n,
    output logic       iow_n,
    output logic       memr_n,
    output logic       memw_n,
    output logic [3:0] dma_acknowledge_internal,
    output logic       end_of_process,
    output logic       eop_n_out,
    output logic       next_word,
    output logic [1:0] dma_rotate
);

    state_t     state_q, state_d;
    logic [1:0] ch_q, ch_d;
    logic       term_q, term_d;
    logic       hrq_q, hrq_d;
    logic       aen_q, aen_d;
    logic       adstb_q, adstb_d;
    logic       ior_n_q, ior_n_d;
    logic       iow_n_q, iow_n_d;
    logic       memr_n_q, memr_n_d;
    logic       memw_n_q, memw_n_d;
    logic [3:0] dack_q, dack_d;
    logic       eop_q, eop_d;
    logic       next_word_q, next_word_d;
    logic [1:0] rotate_q, rotate_d;

    logic [1:0] w_mode;
    logic       w_req;
    logic       w_term;
    logic       w_skip_s1;
    state_t     w_repeat_state;

    assign w_mode = mode_transfer[{ch_q, 1'b0} +: 2];
    assign w_req  = encoded_dma[ch_q];
    // term_q holds any TC/EOP seen during S3; S4 also looks at the live inputs.
    assign w_term = term_q | terminal_count | ~eop_n_in;

`ifdef KF8237_COMPRESSED_TIMING_EN
    assign w_skip_s1 = compressed_timing &&
                       ((w_mode == MODE_BLOCK) || (w_mode == MODE_DEMAND));
`else
    assign w_skip_s1 = 1'b0;
`endif
    assign w_repeat_state = w_skip_s1 ? ST_S2 : ST_S1;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        case (state_q)
            ST_SI: begin
                if ((encoded_dma != 4'b0000) && !controller_disable) begin
                    ch_d    = onehot_to_index(encoded_dma);
                    state_d = ST_S0;
                end
            end
            ST_S0: begin
                if (!w_req) begin
                    state_d = ST_SI;
                end else if (hlda) begin
                    state_d = (w_mode == MODE_CASCADE) ? ST_SC : ST_S1;
                end
            end
            ST_S1: state_d = ST_S2;
            ST_S2: state_d = ST_S3;
            ST_S3: begin
                if (ready) begin
                    state_d = ST_S4;
                end
            end
            ST_S4: begin
                if (!hlda || w_term) begin
                    state_d = ST_SI;
                end else begin
                    case (w_mode)
                        MODE_DEMAND: state_d = w_req ? w_repeat_state : ST_SI;
                        MODE_BLOCK:  state_d = w_repeat_state;
                        default:     state_d = ST_SI;
                    endcase
                end
            end
            ST_SC: begin
                if (!w_req) begin
                    state_d = ST_SI;
                end
            end
            default: state_d = ST_SI;
        endcase
    end

    always_comb begin
        term_d      = (state_q == ST_S3) ? w_term : 1'b0;
        hrq_d       = (state_d != ST_SI);
        aen_d       = (state_d == ST_S1) || (state_d == ST_S2) ||
                      (state_d == ST_S3) || (state_d == ST_S4);
        adstb_d     = (state_d == ST_S1);
        dack_d      = (aen_d || (state_d == ST_SC)) ? (4'b0001 << ch_d) : 4'b0000;
        next_word_d = (state_d == ST_S4);
        eop_d       = (state_q == ST_S4) && w_term;
        rotate_d    = ((state_q == ST_S4) && (state_d == ST_SI)) ? ch_q : rotate_q;
    end

    kf8237_strobe_decoder #(
        .EXTENDED_WRITE (EXTENDED_WRITE)
    ) u_strobe_decoder (
        .state         (state_d),
        .transfer_type (mode_type[{ch_d, 1'b0} +: 2]),
        .ior_n         (ior_n_d),
        .iow_n         (iow_n_d),
        .memr_n        (memr_n_d),
        .memw_n        (memw_n_d)
    );

    always_ff @(posedge clock) begin
        if (!reset_n || master_clear) begin
            state_q     <= ST_SI;
            ch_q        <= 2'd0;
            term_q      <= 1'b0;
            hrq_q       <= 1'b0;
            aen_q       <= 1'b0;
            adstb_q     <= 1'b0;
            ior_n_q     <= 1'b1;
            iow_n_q     <= 1'b1;
            memr_n_q    <= 1'b1;
            memw_n_q    <= 1'b1;
            dack_q      <= 4'b0000;
            eop_q       <= 1'b0;
            next_word_q <= 1'b0;
            rotate_q    <= 2'b11;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            term_q      <= term_d;
            hrq_q       <= hrq_d;
            aen_q       <= aen_d;
            adstb_q     <= adstb_d;
            ior_n_q     <= ior_n_d;
            iow_n_q     <= iow_n_d;
            memr_n_q    <= memr_n_d;
            memw_n_q    <= memw_n_d;
            dack_q      <= dack_d;
            eop_q       <= eop_d;
            next_word_q <= next_word_d;
            rotate_q    <= rotate_d;
        end
    end

    assign hrq                      = hrq_q;
    assign aen                      = aen_q;
    assign adstb                    = adstb_q;
    assign ior_n                    = ior_n_q;
    assign iow_n                    = iow_n_q;
    assign memr_n                   = memr_n_q;
    assign memw_n                   = memw_n_q;
    assign dma_acknowledge_internal = dack_q;
    assign end_of_process           = eop_q;
    assign eop_n_out                = ~eop_q;
    assign next_word                = next_word_q;
    assign dma_rotate               = rotate_q;

endmodule
`default_nettype wire

// File: doc/kf8237_timing_and_control.md
Name: kf8237_timing_and_control

Overview:
- Downstream consumer of the KF8237 priority encoder.
- Takes the one-hot granted channel (encoded_dma) and runs the 8237 bus-cycle state machine: HRQ/HLDA handshake, address strobe, read/write strobes, READY wait states and terminal-count/EOP handling.
- Returns dma_acknowledge_internal, end_of_process and dma_rotate to the priority encoder.
- Pulses next_word to the address/count block once per transferred word.

Parameters:
EXTENDED_WRITE, 0, 1 = write strobe asserted from S2 (with the read strobe) instead of only in S3

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
master_clear  in  1  software clear; same effect as reset
controller_disable  in  1  command bit 2; blocks new cycles from SI
encoded_dma  in  4  one-hot granted channel from priority encoder
mode_transfer  in  8  2 bits/channel: 00 demand, 01 single, 10 block, 11 cascade
mode_type  in  8  2 bits/channel: 00 verify, 01 write (IO->mem), 10 read (mem->IO), 11 illegal (treated as verify)
hlda  in  1  hold acknowledge from CPU
ready  in  1  high = no wait state
terminal_count  in  1  current channel count wrapped (from count block)
eop_n_in  in  1  external EOP, active low
hrq  out  1  hold request
aen  out  1  address enable
adstb  out  1  address strobe
ior_n  out  1  I/O read strobe, active low
iow_n  out  1  I/O write strobe, active low
memr_n  out  1  memory read strobe, active low
memw_n  out  1  memory write strobe, active low
dma_acknowledge_internal  out  4  one-hot DACK of the active channel
end_of_process  out  1  one-cycle EOP pulse to encoder/registers
eop_n_out  out  1  EOP drive, active low
next_word  out  1  one-cycle pulse: advance address, decrement count
dma_rotate  out  2  index of last serviced channel

Behaviour:
- Reset/master_clear:
  - State SI; hrq = aen = adstb = 0; all strobes 1; dma_acknowledge_internal = 0.
  - end_of_process = next_word = 0; eop_n_out = 1; dma_rotate = 2'b11.
  - Reset mid-cycle: all outputs reach these values on the same edge.
- All outputs are registered. Latched channel index ch = encoder of encoded_dma, captured on SI->S0.
- SI: encoded_dma != 0 and !controller_disable -> latch ch, hrq = 1, go S0.
- S0: hlda = 1 -> S1. If encoded_dma[ch] drops before hlda -> hrq = 0, go SI (no DACK, no rotate).
- Cascade (mode 11): S0 -> SC on hlda. SC: dack[ch] = 1, no aen/strobes, holds while encoded_dma[ch]. On drop: hrq = 0, dack = 0, go SI.
- S1: aen = 1, adstb = 1 for this cycle only, dack[ch] = 1 -> S2.
- S2: read strobe on: type 01 ior_n = 0; type 10 memr_n = 0. With EXTENDED_WRITE, the write strobe also goes on here -> S3.
- S3: write strobe on (type 01 memw_n = 0, type 10 iow_n = 0). Verify (type 00) drives no strobes in any state.
  - ready = 0 -> stay S3 with strobes held.
  - ready = 1 -> S4.
- S4: all strobes released; next_word = 1 for one cycle. Decision uses terminal_count or eop_n_in sampled in S3/S4:
  - TC/EOP: end_of_process = 1 and eop_n_out = 0 for one cycle, dack = 0, aen = 0, hrq = 0, dma_rotate = ch, go SI.
  - Else single: release (hrq = 0, dack = 0, dma_rotate = ch) and go SI for re-arbitration.
  - Else demand: encoded_dma[ch] still high -> S1, else release -> SI.
  - Else block: -> S1 regardless of request.
  - hlda = 0 in S4 forces release -> SI. hlda is ignored in S1-S3.
- Simultaneous TC and external EOP: a single end_of_process pulse.

Optional Feature:
KF8237_COMPRESSED_TIMING_EN:
- Defined: adds input compressed_timing (command bit 3). When it is 1 and the mode is block or demand, repeat cycles go S4 -> S2, skipping S1 (no adstb, address MSBs retained). S3 remains.
- Undefined: port absent; repeat cycles always pass S1.

Decomposition:
- Package kf8237_common_pkg holds:
  - state enum (SI, S0, S1, S2, S3, S4, SC);
  - transfer-mode constants (DEMAND/SINGLE/BLOCK/CASCADE);
  - transfer-type constants (VERIFY/WRITE/READ).
- One sub-module: kf8237_strobe_decoder, combinational state + type + EXTENDED_WRITE -> four next-strobe values, registered in the parent.

Test Plan:
- Single write, ch2 (encoded_dma = 0100, type 01, mode 01), hlda after 3 cycles, ready = 1 -> S0 held 3 cycles, then adstb 1 cycle, ior_n low S2-S3, memw_n low S3, next_word 1 pulse, hrq = 0, dma_rotate = 2.
- Block read, ch0, terminal_count asserted on the 3rd word, ready = 1 -> 3 next_word pulses, memr_n/iow_n cycling, end_of_process and eop_n_out low for 1 cycle, dack = 0000.
- READY wait: ready low 4 cycles in S3 -> strobes held 5 cycles total, next_word only after ready rises.
- Demand mode, ch1: request dropped after 2nd word -> exactly 2 words, return to SI. Request withdrawn during S0 -> hrq falls, dack never asserted, dma_rotate unchanged (11).
- Cascade ch3 -> dack = 1000 and all strobes high while requested. reset_n low during S3 -> all outputs at reset values next edge.
- Controller_disable = 1 with encoded_dma = 0001 -> hrq stays 0.
